// File: rtl/um6845r_crtc_if.sv
// CPU register bus of the UM6845R CRTC.
// Master side is the CPU, slave side is the CRTC.
interface um6845r_crtc_if;
    logic       ENABLE;
    logic       nCS;
    logic       R_nW;
    logic       RS;
    logic [7:0] DI;
    logic [7:0] DO;

    modport master (
        output ENABLE, nCS, R_nW, RS, DI,
        input  DO
    );

    modport slave (
        input  ENABLE, nCS, R_nW, RS, DI,
        output DO
    );
endinterface

// File: rtl/um6845r_crtc.sv
// 6845-family CRT controller, HD6845 (type 0) / UM6845R (type 1).
// Optional interlace support is built when CRTC_INTERLACE_EN is defined.
module um6845r_crtc (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          CLKEN,
    input  logic          TYPE,
    um6845r_crtc_if.slave bus,
    output logic          VSYNC,
    output logic          HSYNC,
    output logic          DE,
    output logic          FIELD,
    output logic          CURSOR,
    output logic [13:0]   MA,
    output logic [4:0]    RA
);
    typedef enum logic {V_ROW, V_ADJ} vstate_t;

    logic [4:0]  addr;
    logic [7:0]  r0, r1, r2, r3, r13, r15;
    logic [6:0]  r4, r6, r7, r10;
    logic [4:0]  r5, r9, r11;
    logic [5:0]  r12, r14;

    logic [7:0]  hc;
    logic [6:0]  vc;
    logic [4:0]  ra;
    logic [4:0]  adj;
    logic [13:0] row_base;
    logic [5:0]  blink;
    logic [3:0]  hs_cnt;
    logic [3:0]  vs_cnt;
    vstate_t     vstate, vstate_nxt;

    logic        wr_en;
    logic        line_end;
    logic        row_last;
    logic        frame_end;
    logic        in_vdisp;
    logic        hdisp;
    logic        vs_trig;
    logic        vs_edge;
    logic        blink_on;
    logic [7:0]  vs_hc;
    logic [13:0] ma_cur;
    logic [3:0]  vs_width;

`ifdef CRTC_INTERLACE_EN
    logic        r8_ilace;
    logic        field;
    assign vs_hc = (field && r8_ilace) ? {1'b0, r0[7:1]} : 8'd0;
    assign FIELD = field;
`else
    assign vs_hc = 8'd0;
    assign FIELD = 1'b0;
`endif

    assign wr_en     = bus.ENABLE && !bus.nCS && !bus.R_nW;
    assign line_end  = (hc == r0);
    assign row_last  = (ra == r9);
    assign in_vdisp  = (vc < r6);
    assign hdisp     = (hc < r1);
    assign frame_end = (vstate == V_ROW)
                     ? (row_last && vc == r4 && r5 == 5'd0)
                     : (adj + 5'd1 == r5);
    assign ma_cur    = row_base + {6'd0, hc};
    assign vs_edge   = (hc == vs_hc);
    assign vs_trig   = (vstate == V_ROW) && vc == r7 && ra == 5'd0 && vs_edge;
    assign vs_width  = TYPE ? r3[7:4] - 4'd1 : 4'd15;

    // Register file writes; bus access ignores the character clock
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            addr <= '0;
            r0   <= '0; r1  <= '0; r2  <= '0; r3  <= '0;
            r4   <= '0; r5  <= '0; r6  <= '0; r7  <= '0;
            r9   <= '0; r10 <= '0; r11 <= '0; r12 <= '0;
            r13  <= '0; r14 <= '0; r15 <= '0;
`ifdef CRTC_INTERLACE_EN
            r8_ilace <= 1'b0;
`endif
        end else if (wr_en) begin
            if (!bus.RS) begin
                addr <= bus.DI[4:0];
            end else begin
                case (addr)
                    5'd0:  r0  <= bus.DI;
                    5'd1:  r1  <= bus.DI;
                    5'd2:  r2  <= bus.DI;
                    5'd3:  r3  <= bus.DI;
                    5'd4:  r4  <= bus.DI[6:0];
                    5'd5:  r5  <= bus.DI[4:0];
                    5'd6:  r6  <= bus.DI[6:0];
                    5'd7:  r7  <= bus.DI[6:0];
`ifdef CRTC_INTERLACE_EN
                    5'd8:  r8_ilace <= bus.DI[0];
`endif
                    5'd9:  r9  <= bus.DI[4:0];
                    5'd10: r10 <= bus.DI[6:0];
                    5'd11: r11 <= bus.DI[4:0];
                    5'd12: r12 <= bus.DI[5:0];
                    5'd13: r13 <= bus.DI;
                    5'd14: r14 <= bus.DI[5:0];
                    5'd15: r15 <= bus.DI;
                    default: ;
                endcase
            end
        end
    end

    // Read mux: status on RS=0, start/cursor address on RS=1
    always_comb begin
        bus.DO = 8'h00;
        if (bus.ENABLE && !bus.nCS && bus.R_nW) begin
            if (!bus.RS) begin
                bus.DO = TYPE ? {2'b00, !in_vdisp, 5'b00000} : 8'h00;
            end else begin
                case (addr)
                    5'd12:   bus.DO = TYPE ? {2'b00, r12} : 8'h00;
                    5'd13:   bus.DO = TYPE ? r13 : 8'h00;
                    5'd14:   bus.DO = {2'b00, r14};
                    5'd15:   bus.DO = r15;
                    default: bus.DO = 8'h00;
                endcase
            end
        end
    end

    // Vertical phase register
    always_ff @(posedge CLOCK) begin
        if (RESET) vstate <= V_ROW;
        else       vstate <= vstate_nxt;
    end

    // Vertical phase: character rows, then the adjust lines
    always_comb begin
        vstate_nxt = vstate;
        if (CLKEN && line_end) begin
            if (frame_end)
                vstate_nxt = V_ROW;
            else if (vstate == V_ROW && row_last && vc == r4)
                vstate_nxt = V_ADJ;
        end
    end

    // Character, raster, row and adjust-line counters
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            hc  <= '0;
            ra  <= '0;
            vc  <= '0;
            adj <= '0;
        end else if (CLKEN) begin
            hc <= line_end ? 8'd0 : hc + 8'd1;
            if (line_end) begin
                if (frame_end) begin
                    ra  <= '0;
                    vc  <= '0;
                    adj <= '0;
                end else if (vstate == V_ADJ) begin
                    ra  <= ra + 5'd1;
                    adj <= adj + 5'd1;
                end else if (row_last) begin
                    vc <= vc + 7'd1;
                    ra <= (vc == r4) ? ra + 5'd1 : 5'd0;
                end else begin
                    ra <= ra + 5'd1;
                end
            end
        end
    end

    // Row start address and per-frame blink counter
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            row_base <= '0;
            blink    <= '0;
        end else if (CLKEN) begin
            if (line_end && frame_end) begin
                row_base <= {r12, r13};
                blink    <= blink + 6'd1;
            end else if (vstate == V_ROW && row_last && hc == r1) begin
                row_base <= row_base + {6'd0, r1};
            end
        end
    end

`ifdef CRTC_INTERLACE_EN
    // Field flips at each frame start while interlace is on
    always_ff @(posedge CLOCK) begin
        if (RESET)
            field <= 1'b0;
        else if (CLKEN && line_end && frame_end && r8_ilace)
            field <= !field;
    end
`endif

    // Cursor blink gate from R10[6:5]
    always_comb begin
        blink_on = 1'b0;
        unique case (r10[6:5])
            2'b00: blink_on = 1'b1;
            2'b01: blink_on = 1'b0;
            2'b10: blink_on = !blink[4];
            2'b11: blink_on = !blink[5];
        endcase
    end

    // Video outputs, registered one character behind the counters
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            DE     <= 1'b0;
            CURSOR <= 1'b0;
            HSYNC  <= 1'b0;
            VSYNC  <= 1'b0;
            MA     <= '0;
            RA     <= '0;
            hs_cnt <= '0;
            vs_cnt <= '0;
        end else if (CLKEN) begin
            DE     <= hdisp && in_vdisp;
            MA     <= ma_cur;
            RA     <= ra;
            CURSOR <= hdisp && in_vdisp && blink_on
                   && ma_cur == {r14, r15}
                   && ra >= r10[4:0] && ra <= r11;
            if (hc == r2) begin
                HSYNC  <= 1'b1;
                hs_cnt <= r3[3:0] - 4'd1;
            end else if (hs_cnt != 4'd0) begin
                hs_cnt <= hs_cnt - 4'd1;
            end else begin
                HSYNC <= 1'b0;
            end
            if (vs_trig) begin
                VSYNC  <= 1'b1;
                vs_cnt <= vs_width;
            end else if (vs_edge && VSYNC) begin
                if (vs_cnt == 4'd0) VSYNC  <= 1'b0;
                else                vs_cnt <= vs_cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_um6845r_crtc.sv
// Directed bench for um6845r_crtc: timing, addressing, cursor,
// register reads and reset, with hand-computed expected values.
module tb_um6845r_crtc;
    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        CLKEN;
    logic        TYPE;
    logic        VSYNC, HSYNC, DE, FIELD, CURSOR;
    logic [13:0] MA;
    logic [4:0]  RA;

    um6845r_crtc_if bus ();

    um6845r_crtc dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .CLKEN  (CLKEN),
        .TYPE   (TYPE),
        .bus    (bus),
        .VSYNC  (VSYNC),
        .HSYNC  (HSYNC),
        .DE     (DE),
        .FIELD  (FIELD),
        .CURSOR (CURSOR),
        .MA     (MA),
        .RA     (RA)
    );

    always #5 CLOCK = ~CLOCK;

    localparam int FRAME = 42 * 64;

    int n_assert = 0;
    int n_fail   = 0;

    int de_n, hs_n, vs_n, cur_n;
    int vs_line, cur_line, cur_hc;
    logic [13:0] ma0, ma_r1, ma_39, last_ma;
    logic [4:0]  ra_cur, last_ra;
    logic de39, de40, de_l24, hs49, hs50, hs57, hs58;
    logic [7:0] rdv;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ENABLE = 1'b0;
        bus.nCS    = 1'b1;
        bus.R_nW   = 1'b1;
        bus.RS     = 1'b0;
        bus.DI     = 8'h00;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge CLOCK);
        bus.ENABLE = 1'b1; bus.nCS = 1'b0; bus.R_nW = 1'b0;
        bus.RS = 1'b0; bus.DI = {3'b000, a};
        @(negedge CLOCK);
        bus.RS = 1'b1; bus.DI = d;
        @(negedge CLOCK);
        idle();
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        @(negedge CLOCK);
        bus.ENABLE = 1'b1; bus.nCS = 1'b0; bus.R_nW = 1'b0;
        bus.RS = 1'b0; bus.DI = {3'b000, a};
        @(negedge CLOCK);
        bus.R_nW = 1'b1; bus.RS = 1'b1;
        #1 d = bus.DO;
        idle();
    endtask

    task automatic rd_status(output logic [7:0] d);
        @(negedge CLOCK);
        bus.ENABLE = 1'b1; bus.nCS = 1'b0; bus.R_nW = 1'b1;
        bus.RS = 1'b0;
        #1 d = bus.DO;
        idle();
    endtask

    // Runs n character positions and gathers per-window statistics
    task automatic run_n(input int n);
        de_n = 0; hs_n = 0; vs_n = 0; cur_n = 0;
        vs_line = -1; cur_line = -1; cur_hc = -1;
        CLKEN = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK);
            if (DE)    de_n++;
            if (HSYNC) hs_n++;
            if (VSYNC) begin
                vs_n++;
                if (vs_line < 0) vs_line = i / 64;
            end
            if (CURSOR) begin
                cur_n++;
                if (cur_line < 0) begin
                    cur_line = i / 64;
                    cur_hc   = i % 64;
                end
            end
            if (i == 0)           ma0    = MA;
            if (i == 39)          de39   = DE;
            if (i == 40)          de40   = DE;
            if (i == 49)          hs49   = HSYNC;
            if (i == 50)          hs50   = HSYNC;
            if (i == 57)          hs57   = HSYNC;
            if (i == 58)          hs58   = HSYNC;
            if (i == 3 * 64 + 5)  ra_cur = RA;
            if (i == 7 * 64 + 39) ma_39  = MA;
            if (i == 8 * 64)      ma_r1  = MA;
            if (i == 24 * 64)     de_l24 = DE;
            last_ma = MA;
            last_ra = RA;
        end
        CLKEN = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        CLKEN = 1'b0;
        TYPE  = 1'b1;
        idle();
        repeat (2) @(negedge CLOCK);
        chk("reset_outputs", {VSYNC, HSYNC, DE, FIELD, CURSOR, MA, RA}, 32'd0);
        RESET = 1'b0;
        rd(5'd14, rdv);
        chk("reset_r14", rdv, 8'h00);

        wr(5'd0, 8'd63);  wr(5'd1, 8'd40);  wr(5'd2, 8'd50);
        wr(5'd3, 8'h28);  wr(5'd4, 8'd4);   wr(5'd5, 8'd2);
        wr(5'd6, 8'd3);   wr(5'd7, 8'd4);   wr(5'd9, 8'd7);
        wr(5'd10, 8'h02); wr(5'd11, 8'h03); wr(5'd12, 8'h01);
        wr(5'd13, 8'h00); wr(5'd14, 8'h01); wr(5'd15, 8'h05);

        run_n(FRAME);
        chk("f1_de_count", de_n, 960);
        chk("f1_hsync_count", hs_n, 336);
        chk("f1_vsync_count", vs_n, 128);
        chk("f1_vsync_line", vs_line, 32);
        chk("f1_de_hc39", de39, 1'b1);
        chk("f1_de_hc40", de40, 1'b0);
        chk("f1_de_line24", de_l24, 1'b0);
        chk("f1_hs_hc49", hs49, 1'b0);
        chk("f1_hs_hc50", hs50, 1'b1);
        chk("f1_hs_hc57", hs57, 1'b1);
        chk("f1_hs_hc58", hs58, 1'b0);

        run_n(FRAME);
        chk("f2_ma_start", ma0, 14'h0100);
        chk("f2_ma_row0_hc39", ma_39, 14'h0127);
        chk("f2_ma_row1", ma_r1, 14'h0128);
        chk("f2_cursor_count", cur_n, 2);
        chk("f2_cursor_line", cur_line, 2);
        chk("f2_cursor_hc", cur_hc, 5);
        chk("f2_ra_at_cursor", ra_cur, 5'd3);
        chk("f2_last_ma", last_ma, 14'h0207);
        chk("f2_last_ra", last_ra, 5'd9);

        wr(5'd10, 8'h22);
        TYPE = 1'b0;
        chk("clken_hold_ma", MA, 14'h0207);

        run_n(FRAME);
        chk("f3_cursor_off", cur_n, 0);
        chk("f3_vsync_line", vs_line, 32);
        chk("f3_vsync_count", vs_n, 640);

        run_n(FRAME);
        chk("f4_vsync_count", vs_n, 1024);
        chk("f4_vsync_line", vs_line, 0);

        TYPE = 1'b1;
        wr(5'd12, 8'h3F);
        wr(5'd14, 8'h15);
        rd(5'd12, rdv); chk("t1_r12", rdv, 8'h3F);
        rd(5'd14, rdv); chk("t1_r14", rdv, 8'h15);
        rd_status(rdv); chk("t1_status_disp", rdv, 8'h00);
        TYPE = 1'b0;
        rd(5'd12, rdv); chk("t0_r12", rdv, 8'h00);
        rd(5'd14, rdv); chk("t0_r14", rdv, 8'h15);
        rd(5'd16, rdv); chk("t0_r16", rdv, 8'h00);
        rd_status(rdv); chk("t0_status", rdv, 8'h00);

        TYPE = 1'b1;
        run_n(30 * 64);
        rd_status(rdv); chk("t1_status_vblank", rdv, 8'h20);

        @(negedge CLOCK);
        bus.ENABLE = 1'b1; bus.nCS = 1'b0; bus.R_nW = 1'b0;
        bus.RS = 1'b0; bus.DI = 8'd14;
        @(negedge CLOCK);
        RESET = 1'b1; CLKEN = 1'b1;
        bus.RS = 1'b1; bus.DI = 8'h77;
        @(negedge CLOCK);
        chk("midframe_reset", {VSYNC, HSYNC, DE, FIELD, CURSOR, MA, RA}, 32'd0);
        RESET = 1'b0; CLKEN = 1'b0;
        idle();
        rd(5'd14, rdv);
        chk("post_reset_r14", rdv, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/um6845r_crtc.md
UM6845R_CRTC -- requirements
Module: um6845r_crtc

Interface
REQ-001 CLOCK  in  1  system clock; all state changes on its rising edge.
REQ-002 RESET  in  1  reset, synchronous, active-high.
REQ-003 CLKEN  in  1  character-clock enable; timing counters advance only on cycles with CLKEN=1.
REQ-004 ENABLE  in  1  bus enable; register access only when ENABLE=1.
REQ-005 TYPE  in  1  0 = HD6845-style (type 0), 1 = UM6845R-style (type 1).
REQ-006 nCS  in  1  chip select, active-low.
REQ-007 R_nW  in  1  1 = read, 0 = write.
REQ-008 RS  in  1  0 = address register, 1 = data register.
REQ-009 DI  in  8  write data.
REQ-010 DO  out  8  read data, combinational from the selected register.
REQ-011 VSYNC, HSYNC, DE, FIELD, CURSOR  out  1 each  vertical sync, horizontal sync, display enable, interlace field, cursor.
REQ-012 MA  out  14  memory address; RA  out  5  raster address.
REQ-013 No parameters.

Function
REQ-014 Write on any clock with ENABLE=1, nCS=0, R_nW=0, independent of CLKEN; RS=0 loads the address register (5 bits), RS=1 loads R[addr] when addr<=15; widths: R0-R3 8, R4 7, R5 5, R6-R7 7, R8 2, R9 5, R10 7, R11 5, R12 6, R13 8, R14 6, R15 8.
REQ-015 Read, RS=1: R14/R15 readable in both types; R12/R13 also readable in type 1; R16/R17 read 0; all other registers read 0.
REQ-016 Read, RS=0: type 0 returns 0; type 1 returns bit5 = vertical-blanking flag (not in vertical display area), all other bits 0.
REQ-017 Horizontal counter hc runs 0..R0, then wraps to 0 and ends the scan line.
REQ-018 Within a row, RA counts 0..R9; when RA=R9 at line end, RA returns to 0 and the row counter vc increments.
REQ-019 When vc=R4 and RA=R9 at line end, the block enters an adjust phase of R5 extra lines (RA continues counting), then starts a new frame with vc=0, RA=0; R5=0 means no adjust lines.
REQ-020 DE=1 while hc<R1 and vc<R6.
REQ-021 HSYNC asserts when hc=R2 and lasts R3[3:0] characters, where 0 means 16.
REQ-022 VSYNC asserts at the start of line RA=0 of row vc=R7; type 0 holds it for 16 lines; type 1 holds it for R3[7:4] lines, where 0 means 16.
REQ-023 At frame start, the row base is loaded with {R12,R13}; MA = row base + hc (14-bit wrap).
REQ-024 At hc=R1 on the last raster of a row (RA=R9), row base += R1.
REQ-025 CURSOR=1 when DE=1, MA={R14,R15} and R10[4:0]<=RA<=R11, gated by blink mode R10[6:5]: 00 steady on, 01 off, 10 toggle every 16 frames, 11 toggle every 32 frames.
REQ-026 HSYNC, VSYNC, DE, CURSOR, MA, RA and FIELD are registered and update only on CLKEN cycles.
REQ-027 Register writes take effect at the next counter comparison; no shadowing.

Reset
REQ-028 RESET=1 clears all registers, the address register, hc, vc, RA, the row base, the blink counter and FIELD.
REQ-029 RESET=1 drives all outputs to 0 on the next clock; reset has priority over bus writes and CLKEN.

Configuration
REQ-030 Macro CRTC_INTERLACE_EN, when defined:
- R8[1:0]=x1 enables interlace and FIELD toggles at every frame start.
- In field 1, VSYNC starts half a line late (hc=R0/2).
- Without the macro, R8 is writable and reads 0, FIELD is constant 0, and timing is non-interlaced.

Verification
REQ-031 Program R0=63, R1=40, R2=50, R3=0x28 with TYPE=1 -> line period 64 CLKENs; DE high for hc 0..39; HSYNC high for hc 50..57.
REQ-032 R4=4, R5=2, R6=3, R7=4, R9=7 -> frame of 42 lines; DE active on lines 0..23; VSYNC spans 2 lines (type 1) or 16 lines (type 0) starting at line 32.
REQ-033 R12=0x01, R13=0x00, R1=40 -> MA=0x0100 at frame start; MA=0x0128 at hc=0 of row 1; MA=0x0127 at hc=39 of row 0.
REQ-034 R14=0x01, R15=0x05, R10=0x02, R11=0x03 -> CURSOR high only at MA=0x0105 with RA=2..3; R10=0x22 -> CURSOR never high.
REQ-035 Write R12=0x3F, R14=0x15 and read back -> TYPE=1 returns 0x3F and 0x15; TYPE=0 returns 0x00 and 0x15; R16 reads 0x00.
REQ-036 Assert RESET mid-frame -> all outputs 0 next clock; a read of R14 returns 0x00.
